// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Slot widths here must match the DATA_W/ADDR_W the scheduler is built with.
package regfile_wb_pkg;

  typedef enum logic [1:0] {
    REQ_MEM = 2'd0,
    REQ_ALU = 2'd1,
    REQ_BL  = 2'd2
  } req_e;

  localparam int NREQ      = 3;
  localparam int PC_ADDR   = 15;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                 occ;
    logic [WB_ADDR_W-1:0] wa;
    logic [WB_DATA_W-1:0] wd;
  } wb_slot_t;

  function automatic req_e rr_next(input req_e cur);
    case (cur)
      REQ_MEM: rr_next = REQ_ALU;
      REQ_ALU: rr_next = REQ_BL;
      default: rr_next = REQ_MEM;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arb3.sv
// 3-way round-robin arbiter over an eligibility mask; search order mem, alu, bl
// from the pointer, pointer advances past the winner and holds when idle.
module rr_arb3
  import regfile_wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] elig,
  output logic [2:0] grant,
  output req_e       ptr
);

  req_e       ptr_n;
  logic       hit;
  logic [1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= REQ_MEM;
    else       ptr <= ptr_n;
  end

  always_comb begin
    grant = '0;
    ptr_n = ptr;
    hit   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 2'((int'(ptr) + k) % NREQ);
      if (!hit && elig[idx]) begin
        grant[idx] = 1'b1;
        hit        = 1'b1;
        ptr_n      = rr_next(req_e'(idx));
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler sharing the register-file write port among alu, mem and bl.
// Optional macro REGFILE_WB_FWD_EN adds a combinational forwarding lookup port.
module regfile_wb_sched
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int LR_ADDR = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_wa,
  input  logic [DATA_W-1:0] alu_wd,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic              bl_valid,
  output logic              bl_ready,
  input  logic [DATA_W-1:0] bl_pc,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic [15:0]       busy,
`ifdef REGFILE_WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_ra,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              err_pc_wr
);

  // Handshake: a request transfers when valid & ready at a rising edge; ready is
  // ~occ | grant and grant comes only from registered state, so ready never
  // depends on valid. A slot granted this cycle may refill at the same edge.

  localparam logic [ADDR_W-1:0] PC_WA = ADDR_W'(PC_ADDR);
  localparam logic [ADDR_W-1:0] LR_WA = ADDR_W'(LR_ADDR);

  wb_slot_t          slot    [NREQ];
  logic [NREQ-1:0]   older   [NREQ];   // older[i][j]: slot i captured before slot j
  logic [NREQ-1:0]   older_n [NREQ];
  logic [NREQ-1:0]   occ, occ_n, keep, acc, cap, elig, grant, ready;
  logic [NREQ-1:0]   req_valid;
  logic [ADDR_W-1:0] req_wa  [NREQ];
  logic [DATA_W-1:0] req_wd  [NREQ];
  logic [ADDR_W-1:0] g_wa;
  logic [DATA_W-1:0] g_wd;
  logic              pc_drop;
  req_e              rr_ptr;

  always_comb begin
    req_valid = {bl_valid, alu_valid, mem_valid};
    req_wa[REQ_MEM] = mem_wa;
    req_wd[REQ_MEM] = mem_wd;
    req_wa[REQ_ALU] = alu_wa;
    req_wd[REQ_ALU] = alu_wd;
    req_wa[REQ_BL]  = LR_WA;
    req_wd[REQ_BL]  = bl_pc - DATA_W'(4);
  end

  always_comb begin
    for (int k = 0; k < NREQ; k++) occ[k] = slot[k].occ;
    ready = ~occ | grant;
    acc   = req_valid & ready;
    keep  = occ & ~grant;
    cap   = acc;
    // R15 writes are swallowed: accepted, reported, never stored
    cap[REQ_MEM] = acc[REQ_MEM] && (mem_wa != PC_WA);
    cap[REQ_ALU] = acc[REQ_ALU] && (alu_wa != PC_WA);
    pc_drop = (acc[REQ_MEM] && (mem_wa == PC_WA)) || (acc[REQ_ALU] && (alu_wa == PC_WA));
    occ_n = keep | cap;
  end

  assign mem_ready = ready[REQ_MEM];
  assign alu_ready = ready[REQ_ALU];
  assign bl_ready  = ready[REQ_BL];

  // New captures are younger than survivors; same-edge captures order by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      older_n[i] = '0;
      for (int j = 0; j < NREQ; j++) begin
        if (i == j)                older_n[i][j] = 1'b0;
        else if (cap[i] && cap[j]) older_n[i][j] = (i < j);
        else if (cap[i])           older_n[i][j] = 1'b0;
        else if (cap[j])           older_n[i][j] = keep[i];
        else                       older_n[i][j] = older[i][j];
      end
    end
  end

  always_comb begin
    elig = occ;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && occ[j] && older[j][i] && (slot[j].wa == slot[i].wa)) elig[i] = 1'b0;
      end
    end
  end

  rr_arb3 u_arb (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  always_comb begin
    g_wa = '0;
    g_wd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        g_wa = slot[k].wa;
        g_wd = slot[k].wd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREQ; k++) begin
        slot[k]  <= '0;
        older[k] <= '0;
      end
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      err_pc_wr <= 1'b0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        slot[k].occ <= occ_n[k];
        if (cap[k]) begin
          slot[k].wa <= req_wa[k];
          slot[k].wd <= req_wd[k];
        end
        older[k] <= older_n[k];
      end
      we3       <= |grant;
      err_pc_wr <= pc_drop;
      if (|grant) begin
        wa3 <= g_wa;
        wd3 <= g_wd;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (occ[k]) busy[slot[k].wa] = 1'b1;
    end
    if (we3) busy[wa3] = 1'b1;
    busy[PC_ADDR] = 1'b0;
  end

`ifdef REGFILE_WB_FWD_EN
  logic [NREQ-1:0] fmatch;
  logic            youngest;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = wd3;
    youngest = 1'b0;
    for (int i = 0; i < NREQ; i++) fmatch[i] = occ[i] && (slot[i].wa == fwd_ra);
    if (fwd_ra != PC_WA) begin
      fwd_hit = (|fmatch) || (we3 && (wa3 == fwd_ra));
      for (int i = 0; i < NREQ; i++) begin
        youngest = fmatch[i];
        for (int j = 0; j < NREQ; j++) begin
          if (j != i && fmatch[j] && older[i][j]) youngest = 1'b0;
        end
        if (youngest) fwd_data = slot[i].wd;
      end
    end
  end
`else
  // Without forwarding, dependent reads stall on busy alone.
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table of single writes plus
// hand-written multi-cycle sequences (burst, ordering, streaming, async reset).
module tb_regfile_wb_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alu_valid = 1'b0, mem_valid = 1'b0, bl_valid = 1'b0;
  logic              alu_ready, mem_ready, bl_ready;
  logic [ADDR_W-1:0] alu_wa = '0, mem_wa = '0;
  logic [DATA_W-1:0] alu_wd = '0, mem_wd = '0, bl_pc = '0;
  logic              we3, err_pc_wr;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [15:0]       busy;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]        src;     // 0 mem, 1 alu, 2 bl
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;      // bl_pc for bl entries
    logic              exp_we;
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_wd;
    logic              exp_err;
  } vec_t;

  vec_t vecs[7];

  regfile_wb_sched dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .bl_valid  (bl_valid),
    .bl_ready  (bl_ready),
    .bl_pc     (bl_pc),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .busy      (busy),
    .err_pc_wr (err_pc_wr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    bl_valid  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive_mem(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    mem_valid = 1'b1;
    mem_wa    = wa;
    mem_wd    = wd;
  endtask

  task automatic drive_alu(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    alu_valid = 1'b1;
    alu_wa    = wa;
    alu_wd    = wd;
  endtask

  task automatic drive_bl(input logic [DATA_W-1:0] pc);
    bl_valid = 1'b1;
    bl_pc    = pc;
  endtask

  initial begin
    logic [15:0]              exp_busy;
    logic [ADDR_W+DATA_W-1:0] e;

    vecs[0] = '{2'd1, 4'd3,  32'h0000_0011, 1'b1, 4'd3,  32'h0000_0011, 1'b0};
    vecs[1] = '{2'd0, 4'd7,  32'hDEAD_BEEF, 1'b1, 4'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{2'd2, 4'd0,  32'h0000_0100, 1'b1, 4'd14, 32'h0000_00FC, 1'b0};
    vecs[3] = '{2'd2, 4'd0,  32'h0000_0000, 1'b1, 4'd14, 32'hFFFF_FFFC, 1'b0};
    vecs[4] = '{2'd1, 4'd15, 32'h0000_0055, 1'b0, 4'd0,  32'h0000_0000, 1'b1};
    vecs[5] = '{2'd0, 4'd15, 32'h0000_0077, 1'b0, 4'd0,  32'h0000_0000, 1'b1};
    vecs[6] = '{2'd0, 4'd0,  32'hA5A5_A5A5, 1'b1, 4'd0,  32'hA5A5_A5A5, 1'b0};

    // reset state
    do_reset();
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_wa3", 32'(wa3), 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_pc_wr), 32'd0);
    check("rst_ready", 32'({mem_ready, alu_ready, bl_ready}), 32'h7);

    // table of single writes
    for (int v = 0; v < 7; v++) begin
      exp_busy = vecs[v].exp_we ? (16'h1 << vecs[v].exp_wa) : 16'h0;
      case (vecs[v].src)
        2'd0: begin drive_mem(vecs[v].wa, vecs[v].wd); check("vec_mem_ready", 32'(mem_ready), 32'd1); end
        2'd1: begin drive_alu(vecs[v].wa, vecs[v].wd); check("vec_alu_ready", 32'(alu_ready), 32'd1); end
        default: begin drive_bl(vecs[v].wd); check("vec_bl_ready", 32'(bl_ready), 32'd1); end
      endcase
      step();
      idle();
      check("vec_c1_we3", 32'(we3), 32'd0);
      check("vec_c1_busy", 32'(busy), 32'(exp_busy));
      check("vec_c1_err", 32'(err_pc_wr), 32'(vecs[v].exp_err));
      step();
      check("vec_c2_we3", 32'(we3), 32'(vecs[v].exp_we));
      check("vec_c2_busy", 32'(busy), 32'(exp_busy));
      check("vec_c2_err", 32'(err_pc_wr), 32'd0);
      if (vecs[v].exp_we) begin
        check("vec_c2_wa3", 32'(wa3), 32'(vecs[v].exp_wa));
        check("vec_c2_wd3", wd3, vecs[v].exp_wd);
      end
      step();
      check("vec_c3_we3", 32'(we3), 32'd0);
      check("vec_c3_busy", 32'(busy), 32'd0);
    end

    // three requesters at once: mem, alu, bl on consecutive cycles
    do_reset();
    exp_q.push_back({4'd1, 32'h0000_1111});
    exp_q.push_back({4'd2, 32'h0000_2222});
    exp_q.push_back({4'd14, 32'h0000_00FC});
    drive_mem(4'd1, 32'h0000_1111);
    drive_alu(4'd2, 32'h0000_2222);
    drive_bl(32'h0000_0100);
    check("burst_ready", 32'({mem_ready, alu_ready, bl_ready}), 32'h7);
    step();
    idle();
    check("burst_busy", 32'(busy), 32'h4006);
    check("burst_c1_we3", 32'(we3), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("burst_we3", 32'(we3), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("burst_wa3", 32'(wa3), 32'(e[DATA_W +: ADDR_W]));
        check("burst_wd3", wd3, e[DATA_W-1:0]);
      end
    end
    step();
    check("burst_end_we3", 32'(we3), 32'd0);
    check("burst_end_busy", 32'(busy), 32'd0);

    // same register from mem then alu on the next edge
    do_reset();
    drive_mem(4'd5, 32'h0000_000A);
    step();
    idle();
    drive_alu(4'd5, 32'h0000_000B);
    check("order1_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("order1_a_we3", 32'(we3), 32'd1);
    check("order1_a_wd3", wd3, 32'h0000_000A);
    check("order1_busy", 32'(busy), 32'h0020);
    step();
    check("order1_b_we3", 32'(we3), 32'd1);
    check("order1_b_wd3", wd3, 32'h0000_000B);
    step();
    check("order1_end_busy", 32'(busy), 32'd0);

    // pointer on alu, but the older mem entry for R5 must drain first
    do_reset();
    drive_mem(4'd0, 32'h0000_0000);
    step();
    idle();
    drive_mem(4'd5, 32'h0000_000A);
    drive_alu(4'd5, 32'h0000_000B);
    check("order2_ready", 32'({mem_ready, alu_ready}), 32'h3);
    step();
    idle();
    check("order2_r0_wa3", 32'(wa3), 32'd0);
    step();
    check("order2_a_we3", 32'(we3), 32'd1);
    check("order2_a_wa3", 32'(wa3), 32'd5);
    check("order2_a_wd3", wd3, 32'h0000_000A);
    step();
    check("order2_b_we3", 32'(we3), 32'd1);
    check("order2_b_wd3", wd3, 32'h0000_000B);

    // streaming alu writes R1..R8
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_alu(ADDR_W'(i + 1), 32'((i + 1) * 16));
      check("stream_ready", 32'(alu_ready), 32'd1);
      if (i >= 2) begin
        check("stream_we3", 32'(we3), 32'd1);
        check("stream_wa3", 32'(wa3), 32'(i - 1));
        check("stream_wd3", wd3, 32'((i - 1) * 16));
      end
      step();
    end
    idle();
    check("stream_t1_wa3", 32'(wa3), 32'd7);
    step();
    check("stream_t2_we3", 32'(we3), 32'd1);
    check("stream_t2_wa3", 32'(wa3), 32'd8);
    step();
    check("stream_t3_we3", 32'(we3), 32'd0);

    // asynchronous reset with two slots full
    do_reset();
    drive_mem(4'd1, 32'h0000_0101);
    drive_alu(4'd2, 32'h0000_0202);
    step();
    idle();
    check("areset_pre_busy", 32'(busy), 32'h0006);
    #2;
    reset = 1'b1;
    #1;
    check("areset_ready", 32'({mem_ready, alu_ready, bl_ready}), 32'h7);
    check("areset_we3", 32'(we3), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("areset_post_we3", 32'(we3), 32'd0);
      check("areset_post_busy", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
